// File: rtl/stream_encoder_pkg.sv
// Shared types and default sizing for the stream encoder and its vocab matcher.
package stream_encoder_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SCAN,
        S_EMIT,
        S_DONE
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_MAX_LEN    = 4;

endpackage

// File: rtl/stream_encoder_vocab_matcher.sv
// Vocab table with one registered write port and a combinational prefix compare
// of the addressed entry against the current symbol window.
module vocab_matcher
    import stream_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [ADDR_WIDTH-1:0]         waddr,
    input  logic [LEN_W-1:0]              wlen,
    input  logic [MAX_LEN*DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0]         raddr,
    input  logic [MAX_LEN*DATA_WIDTH-1:0] window,
    input  logic [LEN_W-1:0]              fill,
    output logic                          match,
    output logic [LEN_W-1:0]              len
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [LEN_W-1:0]              len_mem  [DEPTH];
    logic [MAX_LEN*DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [LEN_W-1:0]              entry_len;
    logic [MAX_LEN*DATA_WIDTH-1:0] entry_syms;

    // Only lengths need clearing: a zero length marks the entry invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                len_mem[i] <= '0;
            end
        end else if (we) begin
            len_mem[waddr] <= wlen;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !rst) begin
            data_mem[waddr] <= wdata;
        end
    end

    always_comb begin
        entry_len  = len_mem[raddr];
        entry_syms = data_mem[raddr];
        match      = (entry_len != '0) && (entry_len <= fill);
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
            if ((LEN_W'(k) < entry_len) &&
                (entry_syms[k*DATA_WIDTH +: DATA_WIDTH] != window[k*DATA_WIDTH +: DATA_WIDTH])) begin
                match = 1'b0;
            end
        end
        len = entry_len;
    end

endmodule

// File: rtl/stream_encoder.sv
// Greedy longest-match tokenizer: buffers up to MAX_LEN symbols, scans the
// whole vocab one entry per cycle, then emits the best token and shifts it out.
module stream_encoder
    import stream_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cs,
    input  logic                          cfg_we,
    input  logic [ADDR_WIDTH-1:0]         cfg_addr,
    input  logic [LEN_W-1:0]              cfg_len,
    input  logic [MAX_LEN*DATA_WIDTH-1:0] cfg_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_WIDTH-1:0]         out_id,
    output logic                          out_unk,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done
);

    state_t                        state, state_n;
    logic [LEN_W-1:0]              fill;
    logic                          last_seen;
    logic [MAX_LEN*DATA_WIDTH-1:0] window;
    logic [ADDR_WIDTH-1:0]         scan_addr;
    logic [LEN_W-1:0]              best_len;
    logic [ADDR_WIDTH-1:0]         best_id;
    logic                          ent_match;
    logic [LEN_W-1:0]              ent_len;
    logic [LEN_W-1:0]              consume;
    logic [LEN_W-1:0]              fill_left;
    logic                          in_fire;
    logic                          out_fire;

    vocab_matcher #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_LEN    (MAX_LEN),
        .LEN_W      (LEN_W)
    ) u_matcher (
        .clk    (clk),
        .rst    (rst),
        .we     (cfg_we && (state == S_IDLE)),
        .waddr  (cfg_addr),
        .wlen   (cfg_len),
        .wdata  (cfg_data),
        .raddr  (scan_addr),
        .window (window),
        .fill   (fill),
        .match  (ent_match),
        .len    (ent_len)
    );

    always_comb begin
        state_n   = state;
        in_fire   = (state == S_FILL) && in_valid;
        out_fire  = (state == S_EMIT) && out_ready;
        consume   = (best_len == '0) ? LEN_W'(1) : best_len;
        fill_left = fill - consume;
        unique case (state)
            S_IDLE: if (cs) state_n = S_FILL;
            // Transition on the incoming handshake so FILL never holds a full window.
            S_FILL: begin
                if (!cs) state_n = S_IDLE;
                else if (in_fire && ((fill == LEN_W'(MAX_LEN - 1)) || in_last)) state_n = S_SCAN;
            end
            S_SCAN: begin
                if (!cs) state_n = S_IDLE;
                else if (scan_addr == '1) state_n = S_EMIT;
            end
            S_EMIT: begin
                if (!cs) state_n = S_IDLE;
                else if (out_fire) begin
                    if (last_seen && (fill_left == '0)) state_n = S_DONE;
                    else if (last_seen) state_n = S_SCAN;
                    else state_n = S_FILL;
                end
            end
            S_DONE: if (!cs) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            fill      <= '0;
            last_seen <= 1'b0;
            window    <= '0;
            scan_addr <= '0;
            best_len  <= '0;
            best_id   <= '0;
        end else begin
            state <= state_n;
            if (state_n == S_IDLE) begin
                fill      <= '0;
                last_seen <= 1'b0;
                window    <= '0;
            end else begin
                unique case (state)
                    S_FILL: if (in_fire) begin
                        for (int unsigned i = 0; i < MAX_LEN; i++) begin
                            if (LEN_W'(i) == fill) window[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                        end
                        fill <= fill + LEN_W'(1);
                        if (in_last) last_seen <= 1'b1;
                    end
                    S_SCAN: begin
                        if (ent_match && (ent_len > best_len)) begin
                            best_len <= ent_len;
                            best_id  <= scan_addr;
                        end
                        scan_addr <= scan_addr + ADDR_WIDTH'(1);
                    end
                    S_EMIT: if (out_fire) begin
                        window <= window >> (consume * DATA_WIDTH);
                        fill   <= fill_left;
                    end
                    default: ;
                endcase
            end
            if ((state_n == S_SCAN) && (state != S_SCAN)) begin
                scan_addr <= '0;
                best_len  <= '0;
                best_id   <= '0;
            end
        end
    end

    always_comb begin
        in_ready  = (state == S_FILL);
        out_valid = (state == S_EMIT);
        out_id    = out_valid ? best_id : '0;
        out_unk   = out_valid && (best_len == '0);
        out_last  = out_valid && last_seen && (consume == fill);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
    end

endmodule

// File: tb/tb_stream_encoder.sv
// Scoreboard bench for stream_encoder: tokens expected per stream are queued
// up front and popped as the encoder emits them.
module tb_stream_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [2:0]  cfg_len;
    logic [31:0] cfg_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_id;
    logic        out_unk;
    logic        out_last;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [3:0] id;
        logic       unk;
        logic       last;
    } tok_t;

    tok_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    int    m_len [16];
    string m_sym [16];

    stream_encoder #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .MAX_LEN    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_len   (cfg_len),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_unk   (out_unk),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push_tok(input int id, input bit unk, input bit last);
        tok_t t;
        t.id   = 4'(id);
        t.unk  = unk;
        t.last = last;
        sb.push_back(t);
    endfunction

    // Reference: the window always holds the next min(4, remaining) symbols;
    // longest valid prefix wins, lowest address on ties, unknown consumes one.
    function automatic void model_push(input string s);
        int pos = 0;
        while (pos < s.len()) begin
            int w = (s.len() - pos < 4) ? s.len() - pos : 4;
            int best = 0;
            int bid = 0;
            int cons;
            for (int e = 0; e < 16; e++) begin
                int L = m_len[e];
                if (L != 0 && L <= w && L > best) begin
                    bit ok = 1'b1;
                    for (int k = 0; k < L; k++) if (m_sym[e][k] != s[pos+k]) ok = 1'b0;
                    if (ok) begin best = L; bid = e; end
                end
            end
            cons = (best == 0) ? 1 : best;
            push_tok(bid, best == 0, pos + cons == s.len());
            pos += cons;
        end
    endfunction

    task automatic cfg_write(input int addr, input int len, input string s);
        logic [31:0] d;
        d = '0;
        for (int k = 0; k < s.len(); k++) d[k*8 +: 8] = s[k];
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_len = 3'(len); cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        m_len[addr] = len;
        m_sym[addr] = s;
    endtask

    task automatic common_vocab();
        for (int e = 0; e < 16; e++) begin
            if (m_len[e] != 0) cfg_write(e, 0, "");
        end
        cfg_write(0, 1, "a");
        cfg_write(1, 2, "ab");
        cfg_write(2, 3, "abc");
        cfg_write(3, 1, "b");
    endtask

    task automatic send(input string s, input bit with_last);
        int n;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = s[i]; in_last = with_last && (i == s.len() - 1);
            #1;
            n = 0;
            while (!in_ready && n < 100) begin @(negedge clk); #1; n++; end
            if (!in_ready) begin
                check("in_ready_timeout", 0, 1);
                in_valid = 1'b0; in_last = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        #1;
        while (!done && n < 300) begin @(negedge clk); #1; n++; end
        check(tag, done, 1);
    endtask

    task automatic finish_stream(input string tag);
        wait_done(tag);
        check({tag, "_sb_empty"}, sb.size(), 0);
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_done_held"}, done, 1);
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        #1;
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    task automatic run_stream(input string tag, input string s);
        model_push(s);
        @(negedge clk);
        cs = 1'b1;
        send(s, 1'b1);
        finish_stream(tag);
    endtask

    always @(negedge clk) begin
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_token", 1, 0);
            end else begin
                tok_t t;
                t = sb.pop_front();
                check("out_id", out_id, t.id);
                check("out_unk", out_unk, t.unk);
                check("out_last", out_last, t.last);
            end
        end
    end

    initial begin
        int n;
        logic [3:0] held_id;
        string s;
        rst = 1'b1; cs = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_len = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        for (int e = 0; e < 16; e++) begin m_len[e] = 0; m_sym[e] = ""; end
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_id", out_id, 0);
        check("rst_out_unk", out_unk, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        common_vocab();

        // "abcab" -> abc, ab(last)
        push_tok(2, 0, 0); push_tok(1, 0, 1);
        @(negedge clk); cs = 1'b1;
        send("abcab", 1'b1);
        finish_stream("abcab");

        // "xa" -> unk, a(last)
        push_tok(0, 1, 0); push_tok(0, 0, 1);
        @(negedge clk); cs = 1'b1;
        send("xa", 1'b1);
        finish_stream("xa");

        // Backpressure: hold out_ready low for 5 cycles in EMIT
        push_tok(1, 0, 1);
        out_ready = 1'b0;
        @(negedge clk); cs = 1'b1;
        send("ab", 1'b1);
        n = 0;
        #1;
        while (!out_valid && n < 100) begin @(negedge clk); #1; n++; end
        check("bp_out_valid", out_valid, 1);
        held_id = out_id;
        check("bp_first_id", held_id, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_id", out_id, held_id);
            check("bp_hold_last", out_last, 1);
            check("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk); #1;
        check("bp_released", out_valid, 0);
        finish_stream("bp");

        // Tie at length 2 between entries 1 and 5; also time the scan
        cfg_write(5, 2, "ab");
        push_tok(1, 0, 1);
        @(negedge clk); cs = 1'b1;
        send("ab", 1'b1);
        n = 0;
        #1;
        while (!out_valid && n < 100) begin n++; @(negedge clk); #1; end
        check("scan_cycles", n, 16);
        finish_stream("tie");

        // Abort mid-scan, then configure and rerun
        @(negedge clk); cs = 1'b1;
        send("abca", 1'b0);
        repeat (3) @(negedge clk);
        cs = 1'b0;
        @(negedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        cfg_write(7, 1, "c");
        push_tok(2, 0, 0); push_tok(1, 0, 1);
        @(negedge clk); cs = 1'b1;
        send("abcab", 1'b1);
        finish_stream("rerun");
        push_tok(7, 0, 1);
        @(negedge clk); cs = 1'b1;
        send("c", 1'b1);
        finish_stream("cfg_after_abort");

        // Reset mid-fill clears the vocab
        @(negedge clk); cs = 1'b1;
        send("ab", 1'b0);
        rst = 1'b1; cs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        for (int e = 0; e < 16; e++) begin m_len[e] = 0; m_sym[e] = ""; end
        push_tok(0, 1, 1);
        @(negedge clk); cs = 1'b1;
        send("a", 1'b1);
        finish_stream("after_rst");

        // Random streams against the reference model
        common_vocab();
        cfg_write(9, 3, "bca");
        cfg_write(12, 4, "abca");
        cfg_write(6, 2, "xc");
        for (int r = 0; r < 8; r++) begin
            string alpha;
            int len;
            alpha = "abcx";
            len = $urandom_range(1, 9);
            s = "";
            for (int k = 0; k < len; k++) s = {s, string'(alpha[$urandom_range(0, 3)])};
            run_stream("rand", s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_encoder.md
STREAM_ENCODER -- requirements
Module: stream_encoder

Interface
REQ-001 Parameters (name, default, meaning):
  DATA_WIDTH, 8, symbol width.
  ADDR_WIDTH, 4, vocab address width; DEPTH = 2**ADDR_WIDTH entries.
  MAX_LEN, 4, max symbols per vocab entry and window size.
  LEN_W, $clog2(MAX_LEN+1), length field width.
REQ-002 Ports (name, direction, width, meaning):
  clk, in, 1, single clock.
  rst, in, 1, synchronous active-high reset.
  cs, in, 1, chip select; high = encode, low = idle/config.
  cfg_we, in, 1, vocab write strobe.
  cfg_addr, in, ADDR_WIDTH, vocab entry index.
  cfg_len, in, LEN_W, entry length; 0 = invalid entry.
  cfg_data, in, MAX_LEN*DATA_WIDTH, entry symbols; symbol k in bits [k*DATA_WIDTH +: DATA_WIDTH].
  in_valid, in, 1, input symbol valid.
  in_ready, out, 1, input symbol accepted.
  in_data, in, DATA_WIDTH, input symbol.
  in_last, in, 1, final symbol of stream.
  out_valid, out, 1, token valid.
  out_ready, in, 1, downstream accepts token.
  out_id, out, ADDR_WIDTH, matched vocab index.
  out_unk, out, 1, no entry matched; out_id = 0.
  out_last, out, 1, final token of stream.
  busy, out, 1, state is not IDLE.
  done, out, 1, stream fully encoded.

Function
REQ-003 States: IDLE, FILL, SCAN, EMIT, DONE.
REQ-004 IDLE: cfg_we writes cfg_len and cfg_data to entry cfg_addr next cycle. cfg_we is ignored in every other state. cs=1 -> FILL.
REQ-005 FILL: in_ready=1. A handshake appends in_data at window position fill and increments fill. A handshake with in_last sets last_seen. Go to SCAN when fill==MAX_LEN, or when last_seen and fill>0.
REQ-006 SCAN: checks one entry per cycle, addresses 0..DEPTH-1, so it lasts exactly DEPTH cycles. An entry matches if cfg_len!=0, cfg_len<=fill, and its first cfg_len symbols equal window[0..cfg_len-1]. best is updated only on strictly greater length, so the lowest address wins ties. After address DEPTH-1 -> EMIT.
REQ-007 EMIT: out_valid=1. out_id/out_unk/out_last are held stable until out_ready.
  - On handshake, consume = best_len, or 1 if unk.
  - Window shifts down by consume; fill -= consume.
  - fill==0 and last_seen -> DONE.
  - last_seen and fill>0 -> SCAN.
  - otherwise -> FILL.
REQ-008 out_last=1 in EMIT exactly when last_seen and consume==fill.
REQ-009 in_ready=0 in all states except FILL. out_valid=0 in all states except EMIT.
REQ-010 DONE: done=1, held until cs=0, then IDLE with fill and last_seen cleared.
REQ-011 cs=0 in FILL, SCAN or EMIT aborts: next cycle IDLE, window/fill/last_seen cleared, out_valid=0. Vocab contents are kept.
REQ-012 Latency from the SCAN entry cycle to out_valid is DEPTH cycles.

Reset
REQ-013 rst (sync, active-high) forces IDLE and clears: fill=0, last_seen=0, all vocab lengths=0, in_ready=0, out_valid=0, out_id=0, out_unk=0, out_last=0, busy=0, done=0.
REQ-014 rst overrides cs and cfg_we in the same cycle. Reset mid-operation discards the window and the pending token.

Structure
REQ-015 Package stream_encoder_pkg holds the state enum type and the default parameter constants.
REQ-016 Vocab storage and the per-entry compare live in sub-module vocab_matcher (write port, read address, window, fill in; match and length out, combinational compare).

Verification
Common vocab: 0="a"(0x61) len1, 1="ab" len2, 2="abc" len3, 3="b" len1, all others len0.
REQ-017 Input "abcab" with in_last on final 'b' -> tokens (id2), (id1, out_last=1); then done=1.
REQ-018 Input "xa" -> (out_unk=1, id0) then (id0, out_last=1).
REQ-019 out_ready held low 5 cycles in EMIT -> outputs stable, in_ready=0 throughout; first token released on the first out_ready=1 cycle.
REQ-020 Entry 5="ab" len2 added, input "ab" -> id1 (tie goes to lower address); SCAN measured at 16 cycles.
REQ-021 cs dropped mid-SCAN -> IDLE next cycle, out_valid=0, a cfg write is accepted, and a rerun of "abcab" matches REQ-017.
REQ-022 rst pulsed mid-FILL, then input "a" -> out_unk=1 (vocab cleared).
